// File: rtl/serializador_pkg.sv
// Shared types and defaults for the serializador_dato word serializer.
package serializador_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } estado_t;

    localparam int unsigned ANCHO_DEF  = 8;
    localparam int unsigned DIV_DEF    = 2;
    localparam int unsigned CONT_W_DEF = 16;

    // Bit-index width, with room for the optional parity bit.
    function automatic int unsigned idx_ancho(input int unsigned ancho);
        return $clog2(ancho + 2);
    endfunction

endpackage

// File: rtl/serializador_dato_tick.sv
// Free-running bit-rate divider: tick is high one clk in every DIV.
module generador_tick
    import serializador_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned    CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tick;

    always_comb begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
    end

    // tick is registered from the next count so it equals (r_cnt == DIV-1)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= (CNT_MAX == '0);
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == CNT_MAX);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/serializador_dato.sv
// MSB-first serializer with a one-word holding buffer feeding detector_secuencia.
// Define SERIALIZADOR_PARIDAD_EN to append an even-parity bit to every frame.
module serializador_dato
    import serializador_pkg::*;
#(
    parameter int unsigned ANCHO  = ANCHO_DEF,
    parameter int unsigned DIV    = DIV_DEF,
    parameter int unsigned CONT_W = CONT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ANCHO-1:0]  entrada,
    input  logic              entrada_valida,
    output logic              entrada_listo,
    output logic              dato,
    output logic              dato_valido,
    output logic              ocupado,
    output logic [CONT_W-1:0] palabras_enviadas
);

`ifdef SERIALIZADOR_PARIDAD_EN
    localparam int unsigned TRAMA = ANCHO + 1;
`else
    localparam int unsigned TRAMA = ANCHO;
`endif
    localparam int unsigned      IDX_W   = idx_ancho(ANCHO);
    localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(TRAMA - 1);

    estado_t           r_estado, w_estado_nxt;
    logic [ANCHO-1:0]  r_buf, w_buf_nxt;
    logic              r_buf_lleno, w_buf_lleno_nxt;
    logic [TRAMA-1:0]  r_shift, w_shift_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [CONT_W-1:0] r_cont, w_cont_nxt;
    logic              r_listo, r_dato, r_dato_valido, r_ocupado;
    logic              w_tick, w_acepta, w_carga;

    generador_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    function automatic logic [TRAMA-1:0] trama_de(input logic [ANCHO-1:0] w);
`ifdef SERIALIZADOR_PARIDAD_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Accept and reload are exclusive: accept needs an empty buffer, reload a full one.
    always_comb begin
        w_estado_nxt    = r_estado;
        w_buf_nxt       = r_buf;
        w_buf_lleno_nxt = r_buf_lleno;
        w_shift_nxt     = r_shift;
        w_idx_nxt       = r_idx;
        w_cont_nxt      = r_cont;
        w_carga         = 1'b0;
        w_acepta        = entrada_valida && r_listo;

        if (w_acepta) begin
            w_buf_nxt       = entrada;
            w_buf_lleno_nxt = 1'b1;
        end

        if (w_tick) begin
            case (r_estado)
                IDLE: begin
                    if (r_buf_lleno) begin
                        w_carga      = 1'b1;
                        w_estado_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_idx != IDX_ULT) begin
                        w_shift_nxt = r_shift << 1;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end else begin
                        if (r_cont != '1) begin
                            w_cont_nxt = r_cont + CONT_W'(1);
                        end
                        if (r_buf_lleno) begin
                            w_carga = 1'b1;
                        end else begin
                            w_estado_nxt = IDLE;
                        end
                    end
                end
                default: w_estado_nxt = IDLE;
            endcase
        end

        if (w_carga) begin
            w_shift_nxt     = trama_de(r_buf);
            w_buf_lleno_nxt = 1'b0;
            w_idx_nxt       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado      <= IDLE;
            r_buf         <= '0;
            r_buf_lleno   <= 1'b0;
            r_shift       <= '0;
            r_idx         <= '0;
            r_cont        <= '0;
            r_listo       <= 1'b1;
            r_dato        <= 1'b0;
            r_dato_valido <= 1'b0;
            r_ocupado     <= 1'b0;
        end else begin
            r_estado      <= w_estado_nxt;
            r_buf         <= w_buf_nxt;
            r_buf_lleno   <= w_buf_lleno_nxt;
            r_shift       <= w_shift_nxt;
            r_idx         <= w_idx_nxt;
            r_cont        <= w_cont_nxt;
            r_listo       <= !w_buf_lleno_nxt;
            r_dato        <= (w_estado_nxt == SHIFT) ? w_shift_nxt[TRAMA-1] : 1'b0;
            r_dato_valido <= (w_estado_nxt == SHIFT);
            r_ocupado     <= (w_estado_nxt == SHIFT) || w_buf_lleno_nxt;
        end
    end

    assign entrada_listo     = r_listo;
    assign dato              = r_dato;
    assign dato_valido       = r_dato_valido;
    assign ocupado           = r_ocupado;
    assign palabras_enviadas = r_cont;

endmodule

// File: tb/tb_serializador_dato.sv
// Directed bench for serializador_dato: default DUT (DIV=2) and a DIV=1, CONT_W=2 DUT.
module tb_serializador_dato;

`ifdef SERIALIZADOR_PARIDAD_EN
    localparam int unsigned TRAMA = 9;
`else
    localparam int unsigned TRAMA = 8;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a_ent = 8'h00;
    logic        a_valid = 1'b0;
    logic        a_listo, a_dato, a_dv, a_ocup;
    logic [15:0] a_pal;
    logic [7:0]  b_ent = 8'h00;
    logic        b_valid = 1'b0;
    logic        b_listo, b_dato, b_dv, b_ocup;
    logic [1:0]  b_pal;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  exp_w[8];

    always #5 clk = ~clk;

    serializador_dato u_dut_a (
        .clk               (clk),
        .reset             (reset),
        .entrada           (a_ent),
        .entrada_valida    (a_valid),
        .entrada_listo     (a_listo),
        .dato              (a_dato),
        .dato_valido       (a_dv),
        .ocupado           (a_ocup),
        .palabras_enviadas (a_pal)
    );

    serializador_dato #(.ANCHO(8), .DIV(1), .CONT_W(2)) u_dut_b (
        .clk               (clk),
        .reset             (reset),
        .entrada           (b_ent),
        .entrada_valida    (b_valid),
        .entrada_listo     (b_listo),
        .dato              (b_dato),
        .dato_valido       (b_dv),
        .ocupado           (b_ocup),
        .palabras_enviadas (b_pal)
    );

    // Word feeders: present the queue head, pop on an accepting edge.
    always @(negedge clk) begin
        a_valid = (qa.size() > 0);
        if (qa.size() > 0) a_ent = qa[0];
        b_valid = (qb.size() > 0);
        if (qb.size() > 0) b_ent = qb[0];
    end

    always @(posedge clk) begin
        if (a_valid && a_listo && qa.size() > 0) void'(qa.pop_front());
        if (b_valid && b_listo && qb.size() > 0) void'(qb.pop_front());
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int b);
        if (b < 8) return w[7-b];
        return ^w;
    endfunction

    function automatic logic sel_dv(input int sel);
        return (sel == 0) ? a_dv : b_dv;
    endfunction

    function automatic logic sel_dato(input int sel);
        return (sel == 0) ? a_dato : b_dato;
    endfunction

    function automatic logic [15:0] sel_pal(input int sel);
        return (sel == 0) ? a_pal : 16'(b_pal);
    endfunction

    // Waits for the first bit, then checks n gapless frames from exp_w, each bit held div clk.
    task automatic capture(input int sel, input int n, input int div, input int pal_fin,
                           input string tag);
        int espera = 0;
        while (sel_dv(sel) !== 1'b1 && espera < 40) begin
            @(negedge clk);
            espera++;
        end
        check({tag, " latency"}, 32'(espera >= 1 && espera <= div + 2), 32'd1);
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < int'(TRAMA); b++) begin
                for (int d = 0; d < div; d++) begin
                    check($sformatf("%s f%0d b%0d c%0d", tag, f, b, d),
                          32'({sel_dv(sel), sel_dato(sel)}),
                          32'({1'b1, exp_bit(exp_w[f], b)}));
                    if (sel == 1 && f > 0 && b == 0 && d == 0)
                        check($sformatf("%s pal f%0d", tag, f), 32'(sel_pal(sel)),
                              32'((f < 3) ? f : 3));
                    @(negedge clk);
                end
            end
        end
        check({tag, " end dv/dato"}, 32'({sel_dv(sel), sel_dato(sel)}), 32'd0);
        check({tag, " end pal"}, 32'(sel_pal(sel)), 32'(pal_fin));
    endtask

    initial begin
        int bad;
        int espera;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst listo", 32'(a_listo), 32'd1);
        check("rst dato", 32'(a_dato), 32'd0);
        check("rst dv", 32'(a_dv), 32'd0);
        check("rst ocupado", 32'(a_ocup), 32'd0);
        check("rst pal", 32'(a_pal), 32'd0);
        check("rst b listo", 32'(b_listo), 32'd1);
        reset = 1'b1;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_dv || a_dato || a_ocup || b_dv || b_dato || b_ocup || !a_listo) bad++;
        end
        check("idle quiet", 32'(bad), 32'd0);

        exp_w[0] = 8'hA5;
        qa.push_back(8'hA5);
        capture(0, 1, 2, 1, "a5");

        exp_w[0] = 8'h07;
        qa.push_back(8'h07);
        capture(0, 1, 2, 2, "07");

        exp_w[0] = 8'h3C;
        exp_w[1] = 8'hC3;
        qa.push_back(8'h3C);
        qa.push_back(8'hC3);
        capture(0, 2, 2, 4, "gapless");

        // Abort a frame mid-way with a second word waiting in the buffer.
        qa.push_back(8'hFF);
        qa.push_back(8'h81);
        espera = 0;
        while (a_dv !== 1'b1 && espera < 40) begin
            @(negedge clk);
            espera++;
        end
        check("abort start", 32'(a_dv), 32'd1);
        repeat (8) @(negedge clk);
        check("abort bit4", 32'(a_dato), 32'd1);
        check("abort queued", 32'(qa.size()), 32'd0);
        qa.delete();
        reset = 1'b0;
        #1;
        check("abort dato", 32'(a_dato), 32'd0);
        check("abort listo", 32'(a_listo), 32'd1);
        check("abort dv", 32'(a_dv), 32'd0);
        check("abort ocupado", 32'(a_ocup), 32'd0);
        check("abort pal", 32'(a_pal), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (a_dv || a_dato || a_ocup) bad++;
        end
        check("abort silent", 32'(bad), 32'd0);
        check("abort pal after", 32'(a_pal), 32'd0);

        exp_w[0] = 8'h01;
        exp_w[1] = 8'h80;
        exp_w[2] = 8'hFF;
        exp_w[3] = 8'h55;
        exp_w[4] = 8'hAA;
        for (int i = 0; i < 5; i++) qb.push_back(exp_w[i]);
        capture(1, 5, 1, 3, "div1");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
